// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg
//   Shared definitions for the SPI register block bus and the boot loader:
//   register addresses, command/status bits, the serial-flash READ opcode
//   and the state encodings of the boot sequencer and its status poller.
package spi_regs_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CMD  = 2'd1;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_FINISH = 8'h02;

  localparam int unsigned ST_REQ_NEXT = 7;

  localparam logic [7:0] FLASH_READ = 8'h03;

  // opcode + three address bytes precede the image
  localparam int unsigned HDR_SLOTS = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_CMD,
    S_POLL,
    S_RD_DATA,
    S_RD_SAMPLE,
    S_DONE,
    S_ERR_FIN,
    S_ERR
  } boot_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_RD,
    P_CHK
  } poll_state_t;

endpackage

// File: rtl/spi_bus_poller.sv
// spi_bus_poller
//   Polls the SPI status register until the request-next bit is set or the
//   poll budget is exhausted.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_go         one-cycle start pulse (issued with the command write)
//   i_req_next   status bit ST_REQ_NEXT of the read data
//   o_rd         read strobe request to the command/status register
//   o_ready      one-cycle: byte is ready to be read
//   o_timeout    one-cycle: POLL_TIMEOUT polls without request-next
module spi_bus_poller
  import spi_regs_pkg::*;
#(
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic i_req_next,
  output logic o_rd,
  output logic o_ready,
  output logic o_timeout
);

  localparam int unsigned   CW    = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(POLL_TIMEOUT);

  poll_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= P_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      if (i_go) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (r_state == P_RD) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == P_CHK) begin
        r_first <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    o_rd      = 1'b0;
    o_ready   = 1'b0;
    o_timeout = 1'b0;
    unique case (r_state)
      P_IDLE: if (i_go) w_next = P_RD;
      P_RD: begin
        o_rd   = 1'b1;
        w_next = P_CHK;
      end
      P_CHK: begin
        // status of the first poll predates the start bit, so it is ignored
        if (!r_first && i_req_next) begin
          o_ready = 1'b1;
          w_next  = P_IDLE;
        end else if (r_cnt == LIMIT) begin
          o_timeout = 1'b1;
          w_next    = P_IDLE;
        end else begin
          w_next = P_RD;
        end
      end
      default: w_next = P_IDLE;
    endcase
  end

endmodule

// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//   After reset, drives the SPI register block to issue a flash READ (0x03)
//   from FLASH_ADDR and copies LEN bytes into boot RAM starting at RAM_BASE,
//   holding the CPU in reset until the copy completes.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   bus_cs/we/addr/din, bus_dout   SPI register block port (read data valid
//                                  the cycle after a read strobe)
//   ram_we/addr/data               boot RAM write port
//   busy, done, err                status (done/err sticky until reset)
//   cpu_rst_n                      released only after a successful copy
//   csum                           running byte sum (BOOT_CHECKSUM_EN only)
// Build option:
//   BOOT_CHECKSUM_EN  adds a trailing checksum slot verified against the
//                     8-bit sum of the image bytes.
module spi_boot_loader
  import spi_regs_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR   = 24'h100000,
  parameter int unsigned LEN          = 4096,
  parameter int unsigned RAM_AW       = 16,
  parameter int unsigned RAM_BASE     = 0,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [1:0]        bus_addr,
  output logic [7:0]        bus_din,
  input  logic [7:0]        bus_dout,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [7:0]        csum
`endif
);

`ifdef BOOT_CHECKSUM_EN
  localparam int unsigned XTRA = 1;
`else
  localparam int unsigned XTRA = 0;
`endif
  localparam logic [16:0]       LAST_SLOT = 17'(LEN + HDR_SLOTS - 1 + XTRA);
  localparam logic [16:0]       DATA_END  = 17'(LEN + HDR_SLOTS);
  localparam logic [RAM_AW-1:0] BASE      = RAM_AW'(RAM_BASE);

  boot_state_t       r_state, w_next;
  logic [16:0]       r_slot;
  logic              r_ram_we;
  logic [RAM_AW-1:0] r_ram_addr, r_wptr;
  logic [7:0]        r_ram_data;
  logic [7:0]        w_tx;
  logic              w_go, w_poll_rd, w_ready, w_timeout;
  logic              w_data_slot, w_csum_bad;

  assign w_data_slot = (r_slot >= 17'(HDR_SLOTS)) && (r_slot < DATA_END);
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;

  spi_bus_poller #(
    .POLL_TIMEOUT(POLL_TIMEOUT)
  ) u_poller (
    .clk       (clk),
    .rst       (rst),
    .i_go      (w_go),
    .i_req_next(bus_dout[ST_REQ_NEXT]),
    .o_rd      (w_poll_rd),
    .o_ready   (w_ready),
    .o_timeout (w_timeout)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_csum;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_csum <= '0;
    else if (r_state == S_RD_SAMPLE && w_data_slot) r_csum <= r_csum + bus_dout;
  end
  assign csum       = r_csum;
  assign w_csum_bad = (bus_dout != r_csum);
`else
  assign w_csum_bad = 1'b0;
`endif

  always_comb begin
    case (r_slot)
      17'd0:   w_tx = FLASH_READ;
      17'd1:   w_tx = FLASH_ADDR[23:16];
      17'd2:   w_tx = FLASH_ADDR[15:8];
      17'd3:   w_tx = FLASH_ADDR[7:0];
      default: w_tx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_slot     <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_wptr     <= BASE;
    end else begin
      r_state  <= w_next;
      r_ram_we <= 1'b0;
      if (r_state == S_RD_SAMPLE) begin
        if (w_data_slot) begin
          r_ram_we   <= 1'b1;
          r_ram_addr <= r_wptr;
          r_ram_data <= bus_dout;
          r_wptr     <= r_wptr + 1'b1;
        end
        if (r_slot != LAST_SLOT) r_slot <= r_slot + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    bus_cs    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = REG_DATA;
    bus_din   = '0;
    w_go      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy   = 1'b0;
        w_next = S_WR_DATA;
      end
      S_WR_DATA: begin
        bus_cs  = 1'b1;
        bus_we  = 1'b1;
        bus_din = w_tx;
        w_next  = S_WR_CMD;
      end
      S_WR_CMD: begin
        bus_cs   = 1'b1;
        bus_we   = 1'b1;
        bus_addr = REG_CMD;
        bus_din  = (r_slot == LAST_SLOT) ? (CMD_START | CMD_FINISH) : CMD_START;
        w_go     = 1'b1;
        w_next   = S_POLL;
      end
      S_POLL: begin
        bus_cs   = w_poll_rd;
        bus_addr = w_poll_rd ? REG_CMD : REG_DATA;
        if (w_ready) w_next = S_RD_DATA;
        else if (w_timeout) w_next = S_ERR_FIN;
      end
      S_RD_DATA: begin
        bus_cs = 1'b1;
        w_next = S_RD_SAMPLE;
      end
      S_RD_SAMPLE: begin
        // the finish bit has already gone out with the last command, so a
        // checksum failure goes straight to ERR
        if (r_slot == LAST_SLOT) w_next = w_csum_bad ? S_ERR : S_DONE;
        else w_next = S_WR_DATA;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR_FIN: begin
        bus_cs   = 1'b1;
        bus_we   = 1'b1;
        bus_addr = REG_CMD;
        bus_din  = CMD_FINISH;
        w_next   = S_ERR;
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader
//   Three loader instances (nominal copy, poll timeout, RAM address wrap)
//   share one behavioural SPI register block model that logs every bus and
//   RAM access; expectations are built from the transfer rules directly.
module tb_spi_boot_loader;

  localparam int NI = 3;
`ifdef BOOT_CHECKSUM_EN
  localparam int XT = 1;
`else
  localparam int XT = 0;
`endif

  int          cfg_len [NI] = '{4, 4, 2};
  int          cfg_aw  [NI] = '{16, 16, 2};
  int          cfg_base[NI] = '{0, 0, 3};
  logic [23:0] cfg_fa  [NI] = '{24'h100000, 24'h100000, 24'hABCDEF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[NI];
  logic        cs[NI], we[NI], rwe[NI], busy_o[NI], done_o[NI], err_o[NI], cpu_o[NI];
  logic [1:0]  addr[NI];
  logic [7:0]  din[NI], dout[NI], rdata[NI];
  logic [15:0] a_raddr, b_raddr;
  logic [1:0]  c_raddr;
  logic [15:0] raddr_w[NI];
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_o[NI];
`endif

  always_comb begin
    raddr_w[0] = a_raddr;
    raddr_w[1] = b_raddr;
    raddr_w[2] = {14'd0, c_raddr};
  end

  spi_boot_loader #(.FLASH_ADDR(24'h100000), .LEN(4), .RAM_AW(16), .RAM_BASE(0),
                    .POLL_TIMEOUT(1024)) u_a (
    .clk(clk), .rst(rst_n[0]), .bus_cs(cs[0]), .bus_we(we[0]), .bus_addr(addr[0]),
    .bus_din(din[0]), .bus_dout(dout[0]), .ram_we(rwe[0]), .ram_addr(a_raddr),
    .ram_data(rdata[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
    .cpu_rst_n(cpu_o[0])
`ifdef BOOT_CHECKSUM_EN
    , .csum(csum_o[0])
`endif
  );

  spi_boot_loader #(.FLASH_ADDR(24'h100000), .LEN(4), .RAM_AW(16), .RAM_BASE(0),
                    .POLL_TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst_n[1]), .bus_cs(cs[1]), .bus_we(we[1]), .bus_addr(addr[1]),
    .bus_din(din[1]), .bus_dout(dout[1]), .ram_we(rwe[1]), .ram_addr(b_raddr),
    .ram_data(rdata[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
    .cpu_rst_n(cpu_o[1])
`ifdef BOOT_CHECKSUM_EN
    , .csum(csum_o[1])
`endif
  );

  spi_boot_loader #(.FLASH_ADDR(24'hABCDEF), .LEN(2), .RAM_AW(2), .RAM_BASE(3),
                    .POLL_TIMEOUT(16)) u_c (
    .clk(clk), .rst(rst_n[2]), .bus_cs(cs[2]), .bus_we(we[2]), .bus_addr(addr[2]),
    .bus_din(din[2]), .bus_dout(dout[2]), .ram_we(rwe[2]), .ram_addr(c_raddr),
    .ram_data(rdata[2]), .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]),
    .cpu_rst_n(cpu_o[2])
`ifdef BOOT_CHECKSUM_EN
    , .csum(csum_o[2])
`endif
  );

  // ---------------- SPI register block model + access logs ----------------
  logic [7:0]  img[NI][8];
  logic [7:0]  csb[NI];
  int          ready_after[NI];   // status read (since last cmd) that sets bit7; 0 = never
  logic [7:0]  dwr_log[NI][16];
  logic [7:0]  cmd_log[NI][16];
  logic [15:0] ram_a_log[NI][8];
  logic [7:0]  ram_d_log[NI][8];
  int          dwr_n[NI], cmd_n[NI], stat_n[NI], polls[NI], rd_n[NI], ram_n[NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        dwr_n[i] <= 0; cmd_n[i] <= 0; stat_n[i] <= 0;
        polls[i] <= 0; rd_n[i]  <= 0; ram_n[i]  <= 0;
        dout[i]  <= '0;
      end else begin
        dout[i] <= 8'($urandom);
        if (cs[i] && we[i]) begin
          if (addr[i] == 2'd0) begin
            if (dwr_n[i] < 16) dwr_log[i][dwr_n[i]] <= din[i];
            dwr_n[i] <= dwr_n[i] + 1;
          end else if (addr[i] == 2'd1) begin
            if (cmd_n[i] < 16) cmd_log[i][cmd_n[i]] <= din[i];
            cmd_n[i] <= cmd_n[i] + 1;
            polls[i] <= 0;
          end
        end else if (cs[i]) begin
          if (addr[i] == 2'd1) begin
            polls[i]  <= polls[i] + 1;
            stat_n[i] <= stat_n[i] + 1;
            dout[i]   <= {(ready_after[i] != 0 && polls[i] + 1 >= ready_after[i]),
                          7'($urandom)};
          end else if (addr[i] == 2'd0) begin
            rd_n[i] <= rd_n[i] + 1;
            if (rd_n[i] >= 4 && rd_n[i] - 4 < cfg_len[i]) dout[i] <= img[i][rd_n[i] - 4];
            else if (rd_n[i] >= 4) dout[i] <= csb[i];
          end
        end
        if (rwe[i]) begin
          if (ram_n[i] < 8) begin
            ram_a_log[i][ram_n[i]] <= raddr_w[i];
            ram_d_log[i][ram_n[i]] <= rdata[i];
          end
          ram_n[i] <= ram_n[i] + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outvec(input int i);
    return 64'({cs[i], we[i], addr[i], din[i], rwe[i], raddr_w[i], rdata[i],
                busy_o[i], done_o[i], err_o[i], cpu_o[i]});
  endfunction

  function automatic logic [7:0] exp_tx(input int i, input int k);
    logic [23:0] fa = cfg_fa[i];
    case (k)
      0:       return 8'h03;
      1:       return fa[23:16];
      2:       return fa[15:8];
      3:       return fa[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sum_img(input int i);
    logic [7:0] s = '0;
    for (int k = 0; k < cfg_len[i]; k++) s = s + img[i][k];
    return s;
  endfunction

  task automatic fill_random(input int i);
    for (int k = 0; k < 8; k++) img[i][k] = 8'($urandom);
    csb[i] = sum_img(i);
  endtask

  task automatic wait_end(input int i);
    int n = 0;
    while (!(done_o[i] || err_o[i]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("finish_in_time[%0d]", i), 64'(done_o[i] || err_o[i]), 64'(1));
  endtask

  // Whole-transfer check: every slot writes its tx byte and a start command
  // (start|finish on the last slot), polls ready_after times, and each image
  // byte lands at (RAM_BASE + k) mod 2^RAM_AW.
  task automatic check_run(input int i, input bit ok);
    int t;
    repeat (3) @(negedge clk);
    t = cfg_len[i] + 4 + XT;
    chk($sformatf("data_wr_count[%0d]", i), 64'(dwr_n[i]), 64'(t));
    for (int k = 0; k < t && k < 16; k++)
      chk($sformatf("data_wr[%0d][%0d]", i, k), 64'(dwr_log[i][k]), 64'(exp_tx(i, k)));
    chk($sformatf("cmd_wr_count[%0d]", i), 64'(cmd_n[i]), 64'(t));
    for (int k = 0; k < t && k < 16; k++)
      chk($sformatf("cmd_wr[%0d][%0d]", i, k), 64'(cmd_log[i][k]),
          64'((k == t - 1) ? 8'h03 : 8'h01));
    chk($sformatf("status_reads[%0d]", i), 64'(stat_n[i]), 64'(ready_after[i] * t));
    chk($sformatf("ram_wr_count[%0d]", i), 64'(ram_n[i]), 64'(cfg_len[i]));
    for (int k = 0; k < cfg_len[i] && k < 8; k++) begin
      chk($sformatf("ram_addr[%0d][%0d]", i, k), 64'(ram_a_log[i][k]),
          64'((cfg_base[i] + k) % (1 << cfg_aw[i])));
      chk($sformatf("ram_data[%0d][%0d]", i, k), 64'(ram_d_log[i][k]), 64'(img[i][k]));
    end
    chk($sformatf("done[%0d]", i), 64'(done_o[i]), 64'(ok));
    chk($sformatf("err[%0d]", i), 64'(err_o[i]), 64'(!ok));
    chk($sformatf("cpu_rst_n[%0d]", i), 64'(cpu_o[i]), 64'(ok));
    chk($sformatf("busy_end[%0d]", i), 64'(busy_o[i]), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      ready_after[i] = 3;
      fill_random(i);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outputs[%0d]", i), outvec(i), 64'(0));

    // nominal copy with the fixed image A5 5A 11 22
    img[0][0] = 8'hA5; img[0][1] = 8'h5A; img[0][2] = 8'h11; img[0][3] = 8'h22;
    csb[0] = sum_img(0);
    rst_n[0] = 1'b1;
    wait_end(0);
    check_run(0, 1'b1);
    repeat (5) @(negedge clk);
    chk("done_sticky", 64'(done_o[0]), 64'(1));

    // reset during slot 5, then a full restart with random data
    rst_n[0] = 1'b0;
    fill_random(0);
    ready_after[0] = int'($urandom_range(5, 2));
    @(negedge clk);
    rst_n[0] = 1'b1;
    n = 0;
    while (dwr_n[0] < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_slot5", 64'(dwr_n[0] >= 6), 64'(1));
    chk("busy_mid", 64'(busy_o[0]), 64'(1));
    #2 rst_n[0] = 1'b0;
    #1 chk("async_reset_outputs", outvec(0), 64'(0));
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    wait_end(0);
    check_run(0, 1'b1);

    // status never ready: exactly POLL_TIMEOUT reads, one finish write
    ready_after[1] = 0;
    rst_n[1] = 1'b1;
    wait_end(1);
    repeat (3) @(negedge clk);
    chk("to_status_reads", 64'(stat_n[1]), 64'(8));
    chk("to_cmd_count", 64'(cmd_n[1]), 64'(2));
    chk("to_cmd0", 64'(cmd_log[1][0]), 64'(8'h01));
    chk("to_cmd1", 64'(cmd_log[1][1]), 64'(8'h02));
    chk("to_data_count", 64'(dwr_n[1]), 64'(1));
    chk("to_data0", 64'(dwr_log[1][0]), 64'(8'h03));
    chk("to_ram_writes", 64'(ram_n[1]), 64'(0));
    chk("to_err", 64'(err_o[1]), 64'(1));
    chk("to_done", 64'(done_o[1]), 64'(0));
    chk("to_cpu_rst_n", 64'(cpu_o[1]), 64'(0));
    chk("to_busy", 64'(busy_o[1]), 64'(0));

    // RAM address wrap: base 3 in a 4-entry space
    rst_n[2] = 1'b1;
    wait_end(2);
    check_run(2, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    rst_n[2] = 1'b0;
    img[2][0] = 8'h80; img[2][1] = 8'h90; csb[2] = 8'h10;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    wait_end(2);
    check_run(2, 1'b1);
    chk("csum_out", 64'(csum_o[2]), 64'(8'h10));

    rst_n[2] = 1'b0;
    csb[2] = 8'h11;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    wait_end(2);
    check_run(2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
